// File: rtl/axis_word_packer.sv
// ============================================================================
// axis_word_packer : packs RATIO narrow stream words into one wide word
// Revision: 1.0
// ============================================================================
`default_nettype none

module axis_word_packer #(
  parameter int DIN_WIDTH = 32,
  parameter int RATIO     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIN_WIDTH-1:0]         din,
  input  logic                         din_valid,
  input  logic                         din_last,
  output logic                         din_ready,
  output logic [DIN_WIDTH*RATIO-1:0]   dout,
  output logic [RATIO-1:0]             dout_keep,
  output logic                         dout_last,
  output logic                         dout_valid,
  input  logic                         dout_ready
);

  localparam int DOUT_WIDTH = DIN_WIDTH * RATIO;
  localparam int CNT_W      = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [CNT_W-1:0]      cnt;
  logic [DOUT_WIDTH-1:0] acc;
  logic [RATIO-1:0]      mask;

  logic [DOUT_WIDTH-1:0] lane_data;
  logic [RATIO-1:0]      lane_keep;
  logic                  accept;
  logic                  complete;
  logic                  xfer;

  assign din_ready = !dout_valid || dout_ready;
  assign accept    = din_valid && din_ready;
  assign xfer      = dout_valid && dout_ready;
  assign complete  = accept && ((cnt == CNT_W'(RATIO - 1)) || din_last);

  // Steer the incoming word into its lane; other lanes stay zero so that
  // OR-ing into the accumulator never disturbs earlier lanes.
  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    assign lane_keep[i] = (cnt == CNT_W'(i));
    assign lane_data[i*DIN_WIDTH +: DIN_WIDTH] = lane_keep[i] ? din : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      acc        <= '0;
      mask       <= '0;
      dout       <= '0;
      dout_keep  <= '0;
      dout_last  <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      if (xfer) begin
        dout_valid <= 1'b0;
      end
      if (accept) begin
        if (complete) begin
          // Completion overrides the drain above: back-to-back words keep valid high.
          dout       <= acc | lane_data;
          dout_keep  <= mask | lane_keep;
          dout_last  <= din_last;
          dout_valid <= 1'b1;
          cnt        <= '0;
          acc        <= '0;
          mask       <= '0;
        end else begin
          acc  <= acc | lane_data;
          mask <= mask | lane_keep;
          cnt  <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_word_packer.sv
// ============================================================================
// tb_axis_word_packer : randomized self-checking bench with a frame-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axis_word_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  din = '0;
  logic         din_valid = 1'b0;
  logic         din_last = 1'b0;
  logic         din_ready;
  logic [127:0] dout;
  logic [3:0]   dout_keep;
  logic         dout_last;
  logic         dout_valid;
  logic         dout_ready = 1'b0;

  logic [31:0]  din1 = '0;
  logic         din1_valid = 1'b0;
  logic         din1_last = 1'b0;
  logic         din1_ready;
  logic [31:0]  dout1;
  logic [0:0]   dout1_keep;
  logic         dout1_last;
  logic         dout1_valid;
  logic         dout1_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_word_packer #(.DIN_WIDTH(32), .RATIO(4)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(din_ready), .dout(dout), .dout_keep(dout_keep), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  axis_word_packer #(.DIN_WIDTH(32), .RATIO(1)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(din1_valid), .din_last(din1_last),
    .din_ready(din1_ready), .dout(dout1), .dout_keep(dout1_keep), .dout_last(dout1_last),
    .dout_valid(dout1_valid), .dout_ready(dout1_ready)
  );

  // Frame-level reference: words collect into a list until RATIO or last,
  // then the packed word joins the queue of words still owed downstream.
  typedef struct {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
  } pk_t;

  pk_t         exp_q[$];
  logic [31:0] part[$];

  function automatic void model_accept(logic [31:0] d, logic l);
    pk_t p;
    part.push_back(d);
    if (part.size() == 4 || l) begin
      p.data = '0;
      for (int i = 0; i < part.size(); i++) p.data[i*32 +: 32] = part[i];
      p.keep = 4'((1 << part.size()) - 1);
      p.last = l;
      exp_q.push_back(p);
      part.delete();
    end
  endfunction

  logic         obs_rdy, obs_val, obs_last;
  logic [127:0] obs_dout;
  logic [3:0]   obs_keep;

  // Drive one cycle at the falling edge and capture what the DUT shows
  // before the rising edge that acts on these inputs.
  task automatic pulse(input logic v, input logic [31:0] d, input logic l, input logic r);
    @(negedge clk);
    din_valid  = v;
    din        = v ? d : $urandom;
    din_last   = l;
    dout_ready = r;
    #1;
    obs_rdy  = din_ready;
    obs_val  = dout_valid;
    obs_dout = dout;
    obs_keep = dout_keep;
    obs_last = dout_last;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", dout_valid); end
    checks++; if (dout !== 128'h0 || dout_keep !== 4'h0 || dout_last !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got %h/%h/%0b exp all zero", dout, dout_keep, dout_last); end
    checks++; if (dout1_valid !== 1'b0 || dout1 !== 32'h0) begin
      errors++; $display("FAIL reset_r1 got %0b/%h exp 0/0", dout1_valid, dout1); end
    rst = 1'b1;
    #1;
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", din_ready); end
  endtask

  task automatic test_basic();
    logic ev, er, v, l;
    logic [31:0] d;
    pk_t e;
    int outs = 0;
    for (int i = 0; i < 6; i++) begin
      v = (i < 4); d = 32'(i + 1); l = (i == 3);
      ev = (exp_q.size() != 0); er = 1'b1;
      pulse(v, d, l, 1'b1);
      checks++; if (obs_val !== ev) begin errors++; $display("FAIL basic_valid cyc %0d got %0b exp %0b", i, obs_val, ev); end
      checks++; if (obs_rdy !== er) begin errors++; $display("FAIL basic_ready cyc %0d got %0b exp %0b", i, obs_rdy, er); end
      if (ev) begin
        e = exp_q.pop_front();
        outs++;
        checks++; if (obs_dout !== e.data || obs_keep !== e.keep || obs_last !== e.last) begin
          errors++; $display("FAIL basic_word got %h/%h/%0b exp %h/%h/%0b", obs_dout, obs_keep, obs_last, e.data, e.keep, e.last); end
        checks++; if (obs_dout !== 128'h00000004_00000003_00000002_00000001 || obs_keep !== 4'b1111 || i != 4) begin
          errors++; $display("FAIL basic_const cyc %0d got %h/%h exp 00000004000000030000000200000001/f at cyc 4", i, obs_dout, obs_keep); end
      end
      if (v && er) model_accept(d, l);
    end
    checks++; if (outs != 1) begin errors++; $display("FAIL basic_count got %0d exp 1", outs); end
  endtask

  task automatic test_short();
    logic ev, v, l;
    logic [31:0] d;
    pk_t e;
    int outs = 0;
    for (int i = 0; i < 5; i++) begin
      v = (i < 3); l = (i >= 1);
      d = (i == 0) ? 32'hA : (i == 1) ? 32'hB : 32'hC;
      ev = (exp_q.size() != 0);
      pulse(v, d, l, 1'b1);
      checks++; if (obs_val !== ev) begin errors++; $display("FAIL short_valid cyc %0d got %0b exp %0b", i, obs_val, ev); end
      if (ev) begin
        e = exp_q.pop_front();
        checks++; if (obs_dout !== e.data || obs_keep !== e.keep || obs_last !== e.last) begin
          errors++; $display("FAIL short_word got %h/%h/%0b exp %h/%h/%0b", obs_dout, obs_keep, obs_last, e.data, e.keep, e.last); end
        if (outs == 0) begin
          checks++; if (obs_dout !== 128'h0000000B_0000000A || obs_keep !== 4'b0011 || obs_last !== 1'b1) begin
            errors++; $display("FAIL short_two got %h/%h/%0b exp b0000000a/3/1", obs_dout, obs_keep, obs_last); end
        end else begin
          checks++; if (obs_dout !== 128'hC || obs_keep !== 4'b0001) begin
            errors++; $display("FAIL short_lane0 got %h/%h exp c/1", obs_dout, obs_keep); end
        end
        outs++;
      end
      if (v) model_accept(d, l);
    end
    checks++; if (outs != 2) begin errors++; $display("FAIL short_count got %0d exp 2", outs); end
  endtask

  task automatic test_backpressure();
    logic ev, er, v, l, r;
    logic [31:0] d;
    pk_t e;
    int outs = 0;
    for (int i = 0; i < 17; i++) begin
      v = (i < 15); r = (i >= 14);
      d = (i < 4) ? 32'(32'h11 + i) : (i == 14) ? 32'h21 : $urandom;
      l = (i == 3) || (i == 14);
      ev = (exp_q.size() != 0); er = !ev || r;
      pulse(v, d, l, r);
      checks++; if (obs_val !== ev) begin errors++; $display("FAIL bp_valid cyc %0d got %0b exp %0b", i, obs_val, ev); end
      checks++; if (obs_rdy !== er) begin errors++; $display("FAIL bp_ready cyc %0d got %0b exp %0b", i, obs_rdy, er); end
      if (ev) begin
        e = exp_q[0];
        checks++; if (obs_dout !== e.data || obs_keep !== e.keep || obs_last !== e.last) begin
          errors++; $display("FAIL bp_hold cyc %0d got %h/%h/%0b exp %h/%h/%0b", i, obs_dout, obs_keep, obs_last, e.data, e.keep, e.last); end
        if (r) begin void'(exp_q.pop_front()); outs++; end
      end
      if (v && er) model_accept(d, l);
    end
    checks++; if (outs != 2) begin errors++; $display("FAIL bp_count got %0d exp 2", outs); end
  endtask

  task automatic test_stream();
    logic ev, er, v, l, r;
    logic [31:0] d;
    pk_t e;
    int idx = 0, outs = 0, cyc = 0;
    logic [31:0] words[64];
    for (int i = 0; i < 64; i++) words[i] = $urandom;
    while ((idx < 64 || exp_q.size() != 0) && cyc < 3000) begin
      v = (idx < 64); d = v ? words[idx] : 32'h0; l = v && (idx % 8 == 7);
      r = (cyc < 40) ? 1'b1 : 1'($urandom_range(0, 1));
      ev = (exp_q.size() != 0); er = !ev || r;
      pulse(v, d, l, r);
      checks++; if (obs_val !== ev) begin errors++; $display("FAIL stream_valid cyc %0d got %0b exp %0b", cyc, obs_val, ev); end
      checks++; if (obs_rdy !== er) begin errors++; $display("FAIL stream_ready cyc %0d got %0b exp %0b", cyc, obs_rdy, er); end
      if (ev) begin
        e = exp_q[0];
        checks++; if (obs_dout !== e.data || obs_keep !== e.keep || obs_last !== e.last) begin
          errors++; $display("FAIL stream_word cyc %0d got %h/%h/%0b exp %h/%h/%0b", cyc, obs_dout, obs_keep, obs_last, e.data, e.keep, e.last); end
        if (r) begin void'(exp_q.pop_front()); outs++; end
      end
      if (v && er) begin model_accept(d, l); idx++; end
      cyc++;
    end
    checks++; if (cyc >= 3000) begin errors++; $display("FAIL stream_timeout got %0d words exp 64", idx); end
    checks++; if (outs != 16) begin errors++; $display("FAIL stream_count got %0d exp 16", outs); end
  endtask

  task automatic test_reset_mid();
    logic ev, v;
    logic [31:0] d;
    pk_t e;
    int outs = 0;
    pulse(1'b1, 32'hDEAD0001, 1'b0, 1'b1);
    pulse(1'b1, 32'hDEAD0002, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (dout_valid !== 1'b0 || dout !== 128'h0 || dout_keep !== 4'h0 || dout_last !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %0b/%h/%h/%0b exp all zero", dout_valid, dout, dout_keep, dout_last); end
    part.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      v = (i < 4); d = $urandom;
      ev = (exp_q.size() != 0);
      pulse(v, d, 1'b0, 1'b1);
      checks++; if (obs_val !== ev) begin errors++; $display("FAIL mid_valid cyc %0d got %0b exp %0b", i, obs_val, ev); end
      if (ev) begin
        e = exp_q.pop_front();
        outs++;
        checks++; if (obs_dout !== e.data || obs_keep !== 4'b1111 || obs_last !== 1'b0) begin
          errors++; $display("FAIL mid_word got %h/%h/%0b exp %h/f/0", obs_dout, obs_keep, obs_last, e.data); end
      end
      if (v) model_accept(d, 1'b0);
    end
    checks++; if (outs != 1) begin errors++; $display("FAIL mid_count got %0d exp 1", outs); end
  endtask

  task automatic test_ratio1();
    logic [31:0] prev_d;
    logic        prev_l;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      din1_valid = (i < 5);
      din1 = $urandom;
      din1_last = 1'($urandom_range(0, 1));
      #1;
      checks++; if (din1_ready !== 1'b1) begin errors++; $display("FAIL r1_ready cyc %0d got %0b exp 1", i, din1_ready); end
      if (i > 0) begin
        checks++; if (dout1_valid !== 1'b1 || dout1 !== prev_d || dout1_keep !== 1'b1 || dout1_last !== prev_l) begin
          errors++; $display("FAIL r1_word cyc %0d got %0b/%h/%0b/%0b exp 1/%h/1/%0b", i, dout1_valid, dout1, dout1_keep, dout1_last, prev_d, prev_l); end
      end
      prev_d = din1; prev_l = din1_last;
      @(posedge clk);
    end
    @(negedge clk);
    checks++; if (dout1_valid !== 1'b0) begin errors++; $display("FAIL r1_drain got %0b exp 0", dout1_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_ratio1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
